// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use bubble insertion and dcache-miss freeze for the MIPS pipeline.
// Optional FWD_STATS_EN adds saturating forward/stall event counters.
module hazard_forward_unit #(
  parameter int NSRC      = 2,
  parameter int NOPS      = 2,
  parameter int REGW      = 5,
  parameter int LU_CYCLES = 1,
  parameter int SELW      = $clog2(NSRC + 1)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NSRC-1:0]        src_regWr,
  input  logic [NSRC*REGW-1:0]   src_regDst,
  input  logic [NOPS*REGW-1:0]   exe_src,
  input  logic [NOPS*REGW-1:0]   id_src,
  input  logic                   id_valid,
  input  logic                   exe_memRead,
  input  logic [REGW-1:0]        exe_regDst,
  input  logic                   mem_dreq,
  input  logic                   dhit,
  input  logic                   flush,
  output logic [NOPS*SELW-1:0]   fwd_sel,
  output logic                   stall_fe,
  output logic                   flush_ex,
`ifdef FWD_STATS_EN
  output logic                   stall_all,
  output logic [31:0]            fwd_count,
  output logic [31:0]            stall_count
`else
  output logic                   stall_all
`endif
);

  localparam int CNTW = (LU_CYCLES > 1) ? $clog2(LU_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CNTW-1:0] lu_cnt_r;
  logic [CNTW-1:0] lu_cnt_nxt_s;
  logic            ret_r;
  logic            ret_nxt_s;
  logic            luh_s;
  logic            miss_s;

  assign miss_s = mem_dreq & ~dhit;

  // Bypass select: scan farthest to nearest so the nearest matching source wins.
  always_comb begin
    fwd_sel = {(NOPS*SELW){1'b0}};
    for (int j = 0; j < NOPS; j++) begin
      for (int k = NSRC - 1; k >= 0; k--) begin
        if (src_regWr[k] &&
            (src_regDst[k*REGW +: REGW] == exe_src[j*REGW +: REGW]) &&
            (exe_src[j*REGW +: REGW] != {REGW{1'b0}})) begin
          fwd_sel[j*SELW +: SELW] = SELW'(k + 1);
        end else begin
          fwd_sel[j*SELW +: SELW] = fwd_sel[j*SELW +: SELW];
        end
      end
    end
  end

  // Load-use detection against every ID operand.
  always_comb begin
    luh_s = 1'b0;
    for (int j = 0; j < NOPS; j++) begin
      if (exe_regDst == id_src[j*REGW +: REGW]) begin
        luh_s = 1'b1;
      end else begin
        luh_s = luh_s;
      end
    end
    luh_s = luh_s & exe_memRead & id_valid & (exe_regDst != {REGW{1'b0}});
  end

  // State, bubble counter and resume-target registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= IDLE;
      lu_cnt_r <= {CNTW{1'b0}};
      ret_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      lu_cnt_r <= lu_cnt_nxt_s;
      ret_r    <= ret_nxt_s;
    end
  end

  // Next-state logic; a miss during a bubble run freezes the counter and remembers to resume.
  always_comb begin
    state_nxt_s  = state_r;
    lu_cnt_nxt_s = lu_cnt_r;
    ret_nxt_s    = ret_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          ret_nxt_s   = 1'b0;
          state_nxt_s = MEM_WAIT;
        end else if (luh_s && !flush) begin
          if (LU_CYCLES > 1) begin
            lu_cnt_nxt_s = CNTW'(LU_CYCLES - 1);
            state_nxt_s  = LU_BUBBLE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LU_BUBBLE: begin
        if (flush) begin
          lu_cnt_nxt_s = {CNTW{1'b0}};
          state_nxt_s  = IDLE;
        end else if (miss_s) begin
          ret_nxt_s   = 1'b1;
          state_nxt_s = MEM_WAIT;
        end else begin
          lu_cnt_nxt_s = lu_cnt_r - CNTW'(1);
          if (lu_cnt_r == CNTW'(1)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = LU_BUBBLE;
          end
        end
      end
      MEM_WAIT: begin
        if (dhit) begin
          state_nxt_s = ret_r ? LU_BUBBLE : IDLE;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        lu_cnt_nxt_s = {CNTW{1'b0}};
        ret_nxt_s    = 1'b0;
      end
    endcase
  end

  // Mealy control outputs; forced low while reset is held so nothing leaks from live inputs.
  always_comb begin
    stall_fe  = 1'b0;
    flush_ex  = 1'b0;
    stall_all = 1'b0;
    if (!nRST) begin
      stall_all = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            stall_all = 1'b1;
          end else if (luh_s && !flush) begin
            stall_fe = 1'b1;
            flush_ex = 1'b1;
          end else begin
            stall_all = 1'b0;
          end
        end
        LU_BUBBLE: begin
          if (flush) begin
            stall_all = 1'b0;
          end else if (miss_s) begin
            stall_all = 1'b1;
          end else begin
            stall_fe = 1'b1;
            flush_ex = 1'b1;
          end
        end
        MEM_WAIT: begin
          stall_all = ~dhit;
        end
        default: begin
          stall_all = 1'b0;
        end
      endcase
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwd_count_r;
  logic [31:0] stall_count_r;

  function automatic logic [31:0] count_fwd(input logic [NOPS*SELW-1:0] sel);
    logic [31:0] n;
    n = 32'd0;
    for (int j = 0; j < NOPS; j++) begin
      if (sel[j*SELW +: SELW] != {SELW{1'b0}}) begin
        n = n + 32'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Saturating event counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fwd_count_r   <= 32'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (!stall_all) begin
        fwd_count_r <= sat_add(fwd_count_r, count_fwd(fwd_sel));
      end
      if (stall_fe || stall_all) begin
        stall_count_r <= sat_add(stall_count_r, 32'd1);
      end
    end
  end

  assign fwd_count   = fwd_count_r;
  assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding/LUH vector table plus multi-cycle
// sequences on two instances (LU_CYCLES=1 and LU_CYCLES=3).
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  src_regWr;
  logic [9:0]  src_regDst;
  logic [9:0]  exe_src;
  logic [9:0]  id_src;
  logic        id_valid;
  logic        exe_memRead;
  logic [4:0]  exe_regDst;
  logic        mem_dreq;
  logic        dhit;
  logic        flush;
  logic [3:0]  sel1, sel3;
  logic        fe1, ex1, all1, fe3, ex3, all3;
`ifdef FWD_STATS_EN
  logic [31:0] fc1, sc1, fc3, sc3;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.NSRC(2), .NOPS(2), .REGW(5), .LU_CYCLES(1)) u_dut1 (
    .CLK(clk), .nRST(n_rst), .src_regWr(src_regWr), .src_regDst(src_regDst),
    .exe_src(exe_src), .id_src(id_src), .id_valid(id_valid), .exe_memRead(exe_memRead),
    .exe_regDst(exe_regDst), .mem_dreq(mem_dreq), .dhit(dhit), .flush(flush),
    .fwd_sel(sel1), .stall_fe(fe1), .flush_ex(ex1),
`ifdef FWD_STATS_EN
    .stall_all(all1), .fwd_count(fc1), .stall_count(sc1)
`else
    .stall_all(all1)
`endif
  );

  hazard_forward_unit #(.NSRC(2), .NOPS(2), .REGW(5), .LU_CYCLES(3)) u_dut3 (
    .CLK(clk), .nRST(n_rst), .src_regWr(src_regWr), .src_regDst(src_regDst),
    .exe_src(exe_src), .id_src(id_src), .id_valid(id_valid), .exe_memRead(exe_memRead),
    .exe_regDst(exe_regDst), .mem_dreq(mem_dreq), .dhit(dhit), .flush(flush),
    .fwd_sel(sel3), .stall_fe(fe3), .flush_ex(ex3),
`ifdef FWD_STATS_EN
    .stall_all(all3), .fwd_count(fc3), .stall_count(sc3)
`else
    .stall_all(all3)
`endif
  );

  typedef struct {
    logic [1:0] wr;
    logic [4:0] d0, d1, e0, e1;
    logic       mr;
    logic [4:0] erd;
    logic       idv;
    logic [4:0] i0, i1;
    logic       fl;
    logic [3:0] esel;
    logic       efe;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    src_regWr = 2'b00; src_regDst = 10'd0; exe_src = 10'd0; id_src = 10'd0;
    id_valid = 1'b0; exe_memRead = 1'b0; exe_regDst = 5'd0;
    mem_dreq = 1'b0; dhit = 1'b0; flush = 1'b0;
  endtask

  task automatic set_luh(input logic on);
    exe_memRead = on; exe_regDst = on ? 5'd9 : 5'd0;
    id_src = on ? {5'd9, 5'd1} : 10'd0; id_valid = on;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{2'b11, 5'd8, 5'd8, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0001, 1'b0};
    vt[1]  = '{2'b11, 5'd8, 5'd8, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0};
    vt[2]  = '{2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0};
    vt[3]  = '{2'b10, 5'd8, 5'd8, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0010, 1'b0};
    vt[4]  = '{2'b01, 5'd3, 5'd7, 5'd7, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0100, 1'b0};
    vt[5]  = '{2'b11, 5'd3, 5'd7, 5'd7, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0110, 1'b0};
    vt[6]  = '{2'b00, 5'd5, 5'd5, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0};
    vt[7]  = '{2'b11, 5'd31, 5'd31, 5'd31, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0101, 1'b0};
    vt[8]  = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd1, 5'd9, 1'b0, 4'b0000, 1'b1};
    vt[9]  = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd1, 5'd9, 1'b0, 4'b0000, 1'b0};
    vt[10] = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd1, 5'd9, 1'b0, 4'b0000, 1'b0};
    vt[11] = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0};
    vt[12] = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd2, 1'b1, 4'b0000, 1'b0};
    vt[13] = '{2'b01, 5'd4, 5'd0, 5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd0, 1'b0, 4'b0001, 1'b1};

    clear_inputs();
    n_rst = 1'b0;
    #12;
    chk("reset_fe1", {31'd0, fe1}, 32'd0);
    chk("reset_ex1", {31'd0, ex1}, 32'd0);
    chk("reset_all1", {31'd0, all1}, 32'd0);
    chk("reset_fe3", {31'd0, fe3}, 32'd0);
    chk("reset_all3", {31'd0, all3}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Table: combinational forwarding and load-use detection on the LU_CYCLES=1 instance.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      src_regWr = vt[i].wr; src_regDst = {vt[i].d1, vt[i].d0};
      exe_src = {vt[i].e1, vt[i].e0}; id_src = {vt[i].i1, vt[i].i0};
      exe_memRead = vt[i].mr; exe_regDst = vt[i].erd; id_valid = vt[i].idv; flush = vt[i].fl;
      #2;
      chk($sformatf("vec%0d_sel", i), {28'd0, sel1}, {28'd0, vt[i].esel});
      chk($sformatf("vec%0d_fe", i), {31'd0, fe1}, {31'd0, vt[i].efe});
      chk($sformatf("vec%0d_ex", i), {31'd0, ex1}, {31'd0, vt[i].efe});
      chk($sformatf("vec%0d_all", i), {31'd0, all1}, 32'd0);
    end

    // Single LUH pulse: 1 bubble on LU_CYCLES=1, 3 bubbles on LU_CYCLES=3.
    do_reset();
    @(negedge clk); set_luh(1'b1); #2;
    chk("lu_c0_fe1", {31'd0, fe1}, 32'd1);
    chk("lu_c0_fe3", {31'd0, fe3}, 32'd1);
    chk("lu_c0_ex3", {31'd0, ex3}, 32'd1);
    @(negedge clk); set_luh(1'b0); #2;
    chk("lu_c1_fe1", {31'd0, fe1}, 32'd0);
    chk("lu_c1_fe3", {31'd0, fe3}, 32'd1);
    chk("lu_c1_ex3", {31'd0, ex3}, 32'd1);
    @(negedge clk); #2;
    chk("lu_c2_fe3", {31'd0, fe3}, 32'd1);
    @(negedge clk); #2;
    chk("lu_c3_fe3", {31'd0, fe3}, 32'd0);
    chk("lu_c3_ex3", {31'd0, ex3}, 32'd0);

    // Flush on the second bubble ends the run early.
    @(negedge clk); set_luh(1'b1); #2;
    chk("fl_c0_fe3", {31'd0, fe3}, 32'd1);
    @(negedge clk); set_luh(1'b0); flush = 1'b1; #2;
    chk("fl_c1_fe3", {31'd0, fe3}, 32'd0);
    chk("fl_c1_ex3", {31'd0, ex3}, 32'd0);
    @(negedge clk); flush = 1'b0; #2;
    chk("fl_c2_fe3", {31'd0, fe3}, 32'd0);

    // Miss for 4 cycles then hit; LUH present during the miss must not stall the front end.
    do_reset();
    @(negedge clk); mem_dreq = 1'b1; dhit = 1'b0; set_luh(1'b1);
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("miss_c%0d_all1", c), {31'd0, all1}, 32'd1);
      chk($sformatf("miss_c%0d_fe1", c), {31'd0, fe1}, 32'd0);
      @(negedge clk);
    end
    set_luh(1'b0); dhit = 1'b1; #2;
    chk("miss_hit_all1", {31'd0, all1}, 32'd0);
    chk("miss_hit_fe1", {31'd0, fe1}, 32'd0);
    @(negedge clk); mem_dreq = 1'b0; dhit = 1'b0; #2;
    chk("miss_after_all1", {31'd0, all1}, 32'd0);
    chk("miss_after_fe3", {31'd0, fe3}, 32'd0);

    // Miss during LU_BUBBLE: remaining two bubbles resume after the hit.
    do_reset();
    @(negedge clk); set_luh(1'b1); #2;
    chk("lm_c0_fe3", {31'd0, fe3}, 32'd1);
    @(negedge clk); set_luh(1'b0); mem_dreq = 1'b1; #2;
    chk("lm_c1_all3", {31'd0, all3}, 32'd1);
    @(negedge clk); #2;
    chk("lm_c2_all3", {31'd0, all3}, 32'd1);
    chk("lm_c2_fe3", {31'd0, fe3}, 32'd0);
    @(negedge clk); dhit = 1'b1; #2;
    chk("lm_hit_all3", {31'd0, all3}, 32'd0);
    chk("lm_hit_fe3", {31'd0, fe3}, 32'd0);
    @(negedge clk); mem_dreq = 1'b0; dhit = 1'b0; #2;
    chk("lm_r0_fe3", {31'd0, fe3}, 32'd1);
    chk("lm_r0_ex3", {31'd0, ex3}, 32'd1);
    @(negedge clk); #2;
    chk("lm_r1_fe3", {31'd0, fe3}, 32'd1);
    @(negedge clk); #2;
    chk("lm_r2_fe3", {31'd0, fe3}, 32'd0);

    // Reset asserted mid-bubble.
    do_reset();
    @(negedge clk); set_luh(1'b1);
    @(negedge clk); set_luh(1'b0); #2;
    chk("rb_pre_fe3", {31'd0, fe3}, 32'd1);
    n_rst = 1'b0; #1;
    chk("rb_fe3", {31'd0, fe3}, 32'd0);
    chk("rb_ex3", {31'd0, ex3}, 32'd0);
    @(negedge clk); n_rst = 1'b1; #2;
    chk("rb_rel0_fe3", {31'd0, fe3}, 32'd0);
    @(negedge clk); #2;
    chk("rb_rel1_fe3", {31'd0, fe3}, 32'd0);

    // Reset asserted while waiting on a miss, with the miss still driven.
    do_reset();
    @(negedge clk); mem_dreq = 1'b1;
    @(negedge clk); #2;
    chk("rm_pre_all1", {31'd0, all1}, 32'd1);
    n_rst = 1'b0; #1;
    chk("rm_all1", {31'd0, all1}, 32'd0);
    chk("rm_all3", {31'd0, all3}, 32'd0);
    @(negedge clk); mem_dreq = 1'b0; n_rst = 1'b1; #2;
    chk("rm_rel0_all1", {31'd0, all1}, 32'd0);
    @(negedge clk); #2;
    chk("rm_rel1_all1", {31'd0, all1}, 32'd0);
    chk("rm_rel1_fe1", {31'd0, fe1}, 32'd0);

`ifdef FWD_STATS_EN
    // 5 cycles forwarding both operands, then 2 load-use stall cycles.
    @(negedge clk); clear_inputs(); n_rst = 1'b0;
    @(negedge clk);
    src_regWr = 2'b01; src_regDst = {5'd0, 5'd8}; exe_src = {5'd8, 5'd8}; n_rst = 1'b1;
    repeat (5) @(negedge clk);
    clear_inputs(); set_luh(1'b1);
    repeat (2) @(negedge clk);
    clear_inputs(); #2;
    chk("stats_fwd", fc1, 32'd10);
    chk("stats_stall", sc1, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
